// File: rtl/cpu_pkg.sv
// Shared constants for the 48-bit multi-cycle CPU: word width, reset PC,
// opcode/funct encodings and the control state enumeration.
package cpu_pkg;

  localparam int DATA_W    = 48;
  localparam int AW        = 10;
  localparam int NREGS     = 32;
  localparam int MEM_WORDS = 1024;

  localparam logic [AW-1:0] RESET_PC = 10'h200;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_BEQ   = 6'b010000;
  localparam logic [5:0] OP_J     = 6'b010001;
  localparam logic [5:0] OP_LI    = 6'b011000;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [10:0] F_NOP = 11'd0;
  localparam logic [10:0] F_ADD = 11'd1;
  localparam logic [10:0] F_SUB = 11'd2;
  localparam logic [10:0] F_AND = 11'd3;
  localparam logic [10:0] F_OR  = 11'd4;
  localparam logic [10:0] F_XOR = 11'd5;
  localparam logic [10:0] F_SLL = 11'd6;
  localparam logic [10:0] F_SRL = 11'd7;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_HALTED
  } state_e;

  function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] imm);
    logic signed [15:0] s;
    s = signed'(imm);
    return DATA_W'(s);
  endfunction

endpackage

// File: rtl/cpu_if.sv
// Word-addressed memory port shared by instruction and data memories.
interface cpu_if;
  import cpu_pkg::*;

  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              we;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);

endinterface

// File: rtl/cpu_mem.sv
// Single-port 1024 x 48 memory: asynchronous read, write on rising edge.
module cpu_mem
  import cpu_pkg::*;
(
  input logic clk,
  cpu_if.slave bus
);

  logic [DATA_W-1:0] memory [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (bus.we) memory[bus.addr] <= bus.wdata;
  end

  assign bus.rdata = memory[bus.addr];

endmodule

// File: rtl/cpu_regfile.sv
// 32 x 48 register file, two combinational read ports, one write port; r0 is hardwired to zero.
module regfile
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] registers [NREGS];

  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) registers[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : registers[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : registers[ra2];

endmodule

// File: rtl/cpu.sv
// Multi-cycle, non-pipelined 48-bit CPU: FETCH/DECODE/EXECUTE/MEM/WB sequencer
// around a 32-entry register file and separate instruction/data memories.
module cpu
  import cpu_pkg::*;
(
  input logic clk,
  input logic reset
);

  state_e            state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] alu_q, alu_d, mdr_q, mdr_d;

  logic [5:0]               opcode;
  logic [4:0]               rs, rt, rdst, shamt;
  logic [15:0]              imm;
  logic [10:0]              funct;
  logic signed [DATA_W-1:0] imm_sx;
  logic                     unused_ir;

  assign opcode    = ir_q[36:31];
  assign rs        = ir_q[30:26];
  assign rt        = ir_q[25:21];
  assign rdst      = ir_q[20:16];
  assign imm       = ir_q[15:0];
  assign shamt     = ir_q[15:11];
  assign funct     = ir_q[10:0];
  assign imm_sx    = sext16(imm);
  assign unused_ir = ^ir_q[DATA_W-1:37];

  function automatic logic [DATA_W-1:0] rtype_alu(input logic [10:0] f,
                                                  input logic [DATA_W-1:0] x,
                                                  input logic [DATA_W-1:0] y,
                                                  input logic [4:0] sh);
    logic [DATA_W-1:0] r;
    case (f)
      F_ADD:   r = x + y;
      F_SUB:   r = x - y;
      F_AND:   r = x & y;
      F_OR:    r = x | y;
      F_XOR:   r = x ^ y;
      F_SLL:   r = x << sh;
      F_SRL:   r = x >> sh;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic writes_rf(input logic [5:0] op, input logic [10:0] f);
    logic w;
    case (op)
      OP_RTYPE:             w = (f >= F_ADD) && (f <= F_SRL);
      OP_LI, OP_ADDI, OP_LW: w = 1'b1;
      default:              w = 1'b0;
    endcase
    return w;
  endfunction

  cpu_if imem_bus ();
  cpu_if dmem_bus ();

  cpu_mem imem (.clk(clk), .bus(imem_bus));
  cpu_mem dmem (.clk(clk), .bus(dmem_bus));

  logic [DATA_W-1:0] rf_rd1, rf_rd2, rf_wd;
  logic [4:0]        rf_wa;
  logic              rf_we;

  regfile regfile (
    .clk(clk),
    .ra1(rs),
    .ra2(rt),
    .rd1(rf_rd1),
    .rd2(rf_rd2),
    .we (rf_we),
    .wa (rf_wa),
    .wd (rf_wd)
  );

  // Write strobes are masked by reset so an aborted instruction leaves no trace.
  assign imem_bus.addr  = pc_q;
  assign imem_bus.wdata = '0;
  assign imem_bus.we    = 1'b0;

  assign dmem_bus.addr  = alu_q[AW-1:0];
  assign dmem_bus.wdata = b_q;
  assign dmem_bus.we    = (state_q == S_MEM) && (opcode == OP_SW) && !reset;

  assign rf_we = (state_q == S_WB) && writes_rf(opcode, funct) && !reset;
  assign rf_wa = (opcode == OP_RTYPE) ? rdst : rt;
  assign rf_wd = (opcode == OP_LW) ? mdr_q : alu_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    case (state_q)
      S_FETCH: begin
        ir_d    = imem_bus.rdata;
        pc_d    = pc_q + AW'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = rf_rd1;
        b_d     = rf_rd2;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = S_WB;
        case (opcode)
          OP_RTYPE: alu_d = rtype_alu(funct, a_q, b_q, shamt);
          OP_LI:    alu_d = {{(DATA_W-16){1'b0}}, imm};
          OP_ADDI:  alu_d = a_q + imm_sx;
          OP_LW, OP_SW: begin
            alu_d   = a_q + imm_sx;
            state_d = S_MEM;
          end
          OP_BEQ: begin
            // pc_q already holds PC+1 from FETCH
            if (a_q == b_q) pc_d = pc_q + imm_sx[AW-1:0];
            state_d = S_FETCH;
          end
          OP_J: begin
            pc_d    = imm[AW-1:0];
            state_d = S_FETCH;
          end
          OP_HALT: state_d = S_HALTED;
          default: ;
        endcase
      end
      S_MEM: begin
        mdr_d   = dmem_bus.rdata;
        state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB:     state_d = S_FETCH;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
    a_q   <= a_d;
    b_q   <= b_d;
    alu_q <= alu_d;
    mdr_q <= mdr_d;
  end

endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: directed single-instruction vectors with exact latency checks,
// hand-written multi-cycle sequences, and random programs against an ISA model.
module tb_cpu;

  localparam logic [5:0] T_RTYPE = 6'b000000, T_ADDI = 6'b000001, T_LW = 6'b001000;
  localparam logic [5:0] T_SW = 6'b001001, T_BEQ = 6'b010000, T_J = 6'b010001;
  localparam logic [5:0] T_LI = 6'b011000, T_HALT = 6'b111111;
  localparam logic [47:0] SENT = 48'h5A5A_A5A5_5A5A;
  localparam int K_REG = 0, K_MEM = 1, K_PC = 2;

  logic clk;
  logic reset;
  int checks = 0;
  int errors = 0;

  cpu dut (.clk(clk), .reset(reset));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [47:0] ins;
    logic [47:0] r1v;
    logic [47:0] r2v;
    int          kind;
    int          idx;
    logic [47:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  logic [47:0] m_reg  [32];
  logic [47:0] m_mem  [1024];
  logic [47:0] m_imem [1024];
  int          m_pc;

  function automatic logic [47:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rd, input logic [15:0] imm);
    return {11'd0, op, rs, rd, 5'd0, imm};
  endfunction

  function automatic logic [47:0] enc_r(input logic [10:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rdst,
                                        input logic [4:0] sh);
    return {11'd0, T_RTYPE, rs, rt, rdst, sh, fn};
  endfunction

  function automatic logic [47:0] rnd48();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[47:0];
  endfunction

  function automatic logic [4:0] rr();
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] pc48();
    return {38'd0, dut.pc_q};
  endfunction

  function automatic logic [47:0] obs(input int kind, input int idx);
    if (kind == K_REG) return dut.regfile.registers[idx];
    if (kind == K_MEM) return dut.dmem.memory[idx];
    return pc48();
  endfunction

  // Hold reset across one edge, then wipe all architectural storage.
  task automatic start();
    reset = 1'b1;
    step(1);
    for (int i = 0; i < 1024; i++) begin
      dut.imem.memory[i] = '0;
      dut.dmem.memory[i] = '0;
    end
    for (int i = 0; i < 32; i++) dut.regfile.registers[i] = '0;
  endtask

  // ISA-level reference: executes one instruction, reports its cycle count.
  task automatic m_step(output int lat, output bit halted);
    logic [47:0] ins, a, b, sx, v;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rdst, sh;
    logic [15:0] imm;
    logic [10:0] fn;
    bit          wr;
    ins  = m_imem[m_pc];
    op   = ins[36:31];
    rs   = ins[30:26];
    rt   = ins[25:21];
    rdst = ins[20:16];
    imm  = ins[15:0];
    sh   = ins[15:11];
    fn   = ins[10:0];
    a    = m_reg[rs];
    b    = m_reg[rt];
    sx   = {{32{imm[15]}}, imm};
    m_pc = (m_pc + 1) % 1024;
    halted = 1'b0;
    lat    = 4;
    case (op)
      T_RTYPE: begin
        wr = 1'b1;
        v  = '0;
        case (fn)
          11'd1:   v = a + b;
          11'd2:   v = a - b;
          11'd3:   v = a & b;
          11'd4:   v = a | b;
          11'd5:   v = a ^ b;
          11'd6:   v = a << sh;
          11'd7:   v = a >> sh;
          default: wr = 1'b0;
        endcase
        if (wr && rdst != 5'd0) m_reg[rdst] = v;
      end
      T_LI:   if (rt != 5'd0) m_reg[rt] = {32'd0, imm};
      T_ADDI: if (rt != 5'd0) m_reg[rt] = a + sx;
      T_LW: begin
        v   = a + sx;
        lat = 5;
        if (rt != 5'd0) m_reg[rt] = m_mem[v[9:0]];
      end
      T_SW: begin
        v = a + sx;
        m_mem[v[9:0]] = b;
      end
      T_BEQ: begin
        lat = 3;
        if (a == b) m_pc = (m_pc + int'($signed(imm))) & 1023;
      end
      T_J: begin
        lat  = 3;
        m_pc = int'(imm[9:0]);
      end
      T_HALT: begin
        lat    = 3;
        halted = 1'b1;
      end
      default: ;
    endcase
  endtask

  function automatic logic [47:0] gen_ins();
    logic [47:0] ins;
    logic [5:0]  junk_op;
    case ($urandom_range(0, 8))
      0:       ins = enc_i(T_LI, rr(), rr(), 16'($urandom));
      1:       ins = enc_i(T_ADDI, rr(), rr(), 16'($urandom));
      2, 3:    ins = enc_r(11'($urandom_range(0, 9)), rr(), rr(), rr(), 5'($urandom));
      4:       ins = enc_i(T_LW, rr(), rr(), 16'($urandom));
      5:       ins = enc_i(T_SW, rr(), rr(), 16'($urandom));
      6:       ins = enc_i(T_BEQ, rr(), rr(), 16'($urandom_range(0, 2)));
      7: begin
        case ($urandom_range(0, 2))
          0:       junk_op = 6'h02;
          1:       junk_op = 6'h2A;
          default: junk_op = 6'h3E;
        endcase
        ins = enc_i(junk_op, rr(), rr(), 16'($urandom));
      end
      default: ins = enc_i(T_LI, 5'd0, rr(), 16'($urandom_range(0, 3)));
    endcase
    ins[47:37] = 11'($urandom);
    return ins;
  endfunction

  initial begin
    logic [47:0] bef, v;
    int          lat, total, n;
    bit          halted;

    reset = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      dut.imem.memory[i] = '0;
      dut.dmem.memory[i] = '0;
    end
    for (int i = 0; i < 32; i++) dut.regfile.registers[i] = '0;
    step(2);
    chk("reset_pc", pc48(), 48'h200);
    chk("reset_ir", dut.ir_q, 48'h0);

    vecs.push_back('{"add",     enc_r(11'd1, 5'd1, 5'd2, 5'd3, 5'd0), 48'd5, 48'd7, K_REG, 3, 48'd12, 4});
    vecs.push_back('{"sub",     enc_r(11'd2, 5'd1, 5'd2, 5'd3, 5'd0), 48'd5, 48'd7, K_REG, 3, 48'hFFFF_FFFF_FFFE, 4});
    vecs.push_back('{"and",     enc_r(11'd3, 5'd1, 5'd2, 5'd3, 5'd0), 48'hF0F0_F0F0_F0F0, 48'hFF00_FF00_FF00, K_REG, 3, 48'hF000_F000_F000, 4});
    vecs.push_back('{"or",      enc_r(11'd4, 5'd1, 5'd2, 5'd3, 5'd0), 48'hF0F0_F0F0_F0F0, 48'hFF00_FF00_FF00, K_REG, 3, 48'hFFF0_FFF0_FFF0, 4});
    vecs.push_back('{"xor",     enc_r(11'd5, 5'd1, 5'd2, 5'd3, 5'd0), 48'hF0F0_F0F0_F0F0, 48'hFF00_FF00_FF00, K_REG, 3, 48'h0FF0_0FF0_0FF0, 4});
    vecs.push_back('{"sll",     enc_r(11'd6, 5'd1, 5'd2, 5'd3, 5'd4), 48'h8000_0000_0001, 48'd0, K_REG, 3, 48'h0000_0000_0010, 4});
    vecs.push_back('{"srl",     enc_r(11'd7, 5'd1, 5'd2, 5'd3, 5'd31), 48'h8000_0000_0000, 48'd0, K_REG, 3, 48'h0000_0001_0000, 4});
    vecs.push_back('{"bad_fn",  enc_r(11'd8, 5'd1, 5'd2, 5'd3, 5'd0), 48'd5, 48'd7, K_REG, 3, SENT, 4});
    vecs.push_back('{"r0_wr",   enc_r(11'd1, 5'd1, 5'd1, 5'd0, 5'd0), 48'd4, 48'd0, K_REG, 0, 48'd0, 4});
    vecs.push_back('{"hi_bits", enc_r(11'd1, 5'd1, 5'd2, 5'd3, 5'd0) | {11'h7FF, 37'd0}, 48'd5, 48'd7, K_REG, 3, 48'd12, 4});
    vecs.push_back('{"li",      enc_i(T_LI, 5'd1, 5'd4, 16'hFFFF), 48'd9, 48'd0, K_REG, 4, 48'h0000_0000_FFFF, 4});
    vecs.push_back('{"addi_neg", enc_i(T_ADDI, 5'd1, 5'd5, 16'hFFF9), 48'd5, 48'd0, K_REG, 5, 48'hFFFF_FFFF_FFFE, 4});
    vecs.push_back('{"addi_wrap", enc_i(T_ADDI, 5'd1, 5'd6, 16'h0001), 48'hFFFF_FFFF_FFFF, 48'd0, K_REG, 6, 48'd0, 4});
    vecs.push_back('{"lw",      enc_i(T_LW, 5'd1, 5'd7, 16'h0003), 48'd7, 48'd0, K_REG, 7, 48'hABCD_EF01_2345, 5});
    vecs.push_back('{"lw_addr10", enc_i(T_LW, 5'd1, 5'd7, 16'h0000), 48'h1234_0000_040A, 48'd0, K_REG, 7, 48'hABCD_EF01_2345, 5});
    vecs.push_back('{"sw",      enc_i(T_SW, 5'd1, 5'd2, 16'hFFFE), 48'd14, 48'h1111_2222_3333, K_MEM, 12, 48'h1111_2222_3333, 4});
    vecs.push_back('{"beq_t",   enc_i(T_BEQ, 5'd1, 5'd2, 16'h0005), 48'd9, 48'd9, K_PC, 0, 48'h206, 3});
    vecs.push_back('{"beq_nt",  enc_i(T_BEQ, 5'd1, 5'd2, 16'h0005), 48'd1, 48'd2, K_PC, 0, 48'h201, 3});
    vecs.push_back('{"beq_back", enc_i(T_BEQ, 5'd1, 5'd2, 16'hFFFD), 48'd3, 48'd3, K_PC, 0, 48'h1FE, 3});
    vecs.push_back('{"j",       enc_i(T_J, 5'd0, 5'd0, 16'hFFFF), 48'd0, 48'd0, K_PC, 0, 48'h3FF, 3});
    vecs.push_back('{"bad_op",  enc_i(6'h2A, 5'd1, 5'd3, 16'h1234), 48'd1, 48'd0, K_REG, 3, SENT, 4});

    foreach (vecs[vi]) begin
      start();
      dut.regfile.registers[1] = vecs[vi].r1v;
      dut.regfile.registers[2] = vecs[vi].r2v;
      if (vecs[vi].kind == K_REG && vecs[vi].idx != 0) dut.regfile.registers[vecs[vi].idx] = SENT;
      dut.dmem.memory[10] = 48'hABCD_EF01_2345;
      if (vecs[vi].kind == K_MEM) dut.dmem.memory[vecs[vi].idx] = SENT;
      dut.imem.memory[10'h200] = vecs[vi].ins;
      dut.imem.memory[10'h201] = enc_i(T_HALT, 5'd0, 5'd0, 16'd0);
      reset = 1'b0;
      step(vecs[vi].lat - 1);
      if (vecs[vi].kind == K_PC)       bef = 48'h201;
      else if (vecs[vi].kind == K_REG && vecs[vi].idx == 0) bef = 48'd0;
      else                              bef = SENT;
      chk({vecs[vi].name, "_early"}, obs(vecs[vi].kind, vecs[vi].idx), bef);
      step(1);
      chk(vecs[vi].name, obs(vecs[vi].kind, vecs[vi].idx), vecs[vi].exp);
    end

    // Load/add/store program, 40 cycles of budget.
    start();
    dut.dmem.memory[16] = 48'd20;
    dut.dmem.memory[32] = 48'd22;
    dut.imem.memory[10'h200] = enc_i(T_LI, 5'd0, 5'd17, 16'd16);
    dut.imem.memory[10'h201] = enc_i(T_LI, 5'd0, 5'd18, 16'd32);
    dut.imem.memory[10'h202] = enc_i(T_LI, 5'd0, 5'd19, 16'd48);
    dut.imem.memory[10'h203] = enc_i(T_LW, 5'd17, 5'd16, 16'd0);
    dut.imem.memory[10'h204] = enc_i(T_LW, 5'd18, 5'd20, 16'd0);
    dut.imem.memory[10'h205] = enc_r(11'd1, 5'd16, 5'd20, 5'd21, 5'd0);
    dut.imem.memory[10'h206] = enc_i(T_SW, 5'd19, 5'd21, 16'd0);
    dut.imem.memory[10'h207] = enc_i(T_HALT, 5'd0, 5'd0, 16'd0);
    reset = 1'b0;
    step(40);
    chk("prog_dmem48", dut.dmem.memory[48], 48'd42);
    chk("prog_r16", dut.regfile.registers[16], 48'd20);
    chk("prog_r20", dut.regfile.registers[20], 48'd22);
    chk("prog_r21", dut.regfile.registers[21], 48'd42);

    // LI then ADDI with negative immediate.
    start();
    dut.imem.memory[10'h200] = enc_i(T_LI, 5'd0, 5'd1, 16'd5);
    dut.imem.memory[10'h201] = enc_i(T_ADDI, 5'd1, 5'd2, 16'hFFF9);
    dut.imem.memory[10'h202] = enc_i(T_HALT, 5'd0, 5'd0, 16'd0);
    reset = 1'b0;
    step(11);
    chk("li_addi_r2", dut.regfile.registers[2], 48'hFFFF_FFFF_FFFE);

    // Taken branch skips LI r2; PC frozen once halted.
    start();
    dut.imem.memory[10'h200] = enc_i(T_LI, 5'd0, 5'd1, 16'd3);
    dut.imem.memory[10'h201] = enc_i(T_BEQ, 5'd1, 5'd1, 16'd1);
    dut.imem.memory[10'h202] = enc_i(T_LI, 5'd0, 5'd2, 16'd9);
    dut.imem.memory[10'h203] = enc_i(T_HALT, 5'd0, 5'd0, 16'd0);
    reset = 1'b0;
    step(10);
    chk("beq_skip_r2", dut.regfile.registers[2], 48'd0);
    chk("halt_pc", pc48(), 48'h204);
    step(6);
    chk("halt_pc_hold", pc48(), 48'h204);
    chk("halt_r2_hold", dut.regfile.registers[2], 48'd0);

    // PC wraps from 1023 to 0.
    start();
    dut.imem.memory[10'h200] = enc_i(T_J, 5'd0, 5'd0, 16'h03FF);
    dut.imem.memory[10'h3FF] = enc_i(T_LI, 5'd0, 5'd5, 16'h0077);
    dut.imem.memory[10'h000] = enc_i(T_HALT, 5'd0, 5'd0, 16'd0);
    reset = 1'b0;
    step(10);
    chk("wrap_r5", dut.regfile.registers[5], 48'h77);
    chk("wrap_pc", pc48(), 48'h1);

    // Reset during SW's MEM cycle, then a clean rerun.
    start();
    dut.regfile.registers[2] = 48'h1234;
    dut.dmem.memory[5] = SENT;
    dut.imem.memory[10'h200] = enc_i(T_SW, 5'd0, 5'd2, 16'd5);
    reset = 1'b0;
    step(3);
    reset = 1'b1;
    step(1);
    chk("sw_abort_mem", dut.dmem.memory[5], SENT);
    chk("sw_abort_pc", pc48(), 48'h200);
    reset = 1'b0;
    step(1);
    chk("first_fetch_pc", pc48(), 48'h201);
    step(3);
    chk("sw_rerun_mem", dut.dmem.memory[5], 48'h1234);

    // Reset during LW's WB cycle.
    start();
    dut.regfile.registers[7] = SENT;
    dut.dmem.memory[0] = 48'd99;
    dut.imem.memory[10'h200] = enc_i(T_LW, 5'd0, 5'd7, 16'd0);
    reset = 1'b0;
    step(4);
    reset = 1'b1;
    step(1);
    chk("lw_abort_reg", dut.regfile.registers[7], SENT);

    // Random programs against the reference model.
    for (int p = 0; p < 8; p++) begin
      start();
      for (int i = 0; i < 1024; i++) begin
        v = rnd48();
        dut.dmem.memory[i] = v;
        m_mem[i]  = v;
        m_imem[i] = '0;
      end
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      for (int i = 1; i < 8; i++) begin
        v = rnd48();
        dut.regfile.registers[i] = v;
        m_reg[i] = v;
      end
      for (int i = 0; i < 32; i++) begin
        v = (i < 20) ? gen_ins() : enc_i(T_HALT, 5'd0, 5'd0, 16'd0);
        m_imem[10'h200 + i] = v;
        dut.imem.memory[10'h200 + i] = v;
      end
      m_pc   = 'h200;
      total  = 0;
      n      = 0;
      halted = 1'b0;
      while (!halted && n < 200) begin
        m_step(lat, halted);
        total += lat;
        n++;
      end
      reset = 1'b0;
      step(total);
      for (int i = 0; i < 32; i++)
        chk($sformatf("rnd%0d_r%0d", p, i), dut.regfile.registers[i], m_reg[i]);
      for (int i = 0; i < 1024; i++)
        chk($sformatf("rnd%0d_m%0d", p, i), dut.dmem.memory[i], m_mem[i]);
      chk($sformatf("rnd%0d_pc", p), pc48(), 48'(m_pc));
      step(4);
      chk($sformatf("rnd%0d_pc_hold", p), pc48(), 48'(m_pc));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
